seq_chunk_adder: RTL
====================

// Module: seq_chunk_adder
// PURPOSE
//  Multi-cycle, parametrised ripple-carry adder: adds two WIDTH-bit operands CHUNK bits per clock.
//  Carry is held in a register between chunks.
//  Successor to the fixed 8-bit combinational adder; trades latency for a short carry chain at large WIDTH.
//  Sits behind a start/busy/done handshake; result width WIDTH+1 (carry-out in MSB).
// PARAMETERS
//  WIDTH  32  operand width in bits; must be a multiple of CHUNK
//  CHUNK  8   bits added per cycle; NCHUNK = WIDTH/CHUNK (>=1)
// PORTS
//  clk      in   1        rising-edge clock
//  rst_n    in   1        synchronous active-low reset
//  start    in   1        request; accepted only when busy=0
//  a        in   WIDTH    operand A; sampled on the accepting edge only
//  b        in   WIDTH    operand B; sampled on the accepting edge only
//  cin      in   1        carry-in; sampled on the accepting edge only
//  busy     out  1        operation in progress
//  done     out  1        one-cycle pulse: sum valid
//  sum      out  WIDTH+1  {carry_out, sum}; held until next accepted start
// BEHAVIOUR
//  - Reset (rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, sum=0; idx=0, carry=0.
//  - Reset overrides everything, including mid-operation: the aborted op never produces done.
//  - FSM states: IDLE, RUN.
//    IDLE->RUN on start=1. Latch a, b and carry=cin. Set idx=0, sum=0, busy=1.
//    RUN: each edge adds chunk idx (bits idx*CHUNK +: CHUNK) plus carry, then:
//      write the result into sum chunk idx;
//      carry <= chunk carry-out;
//      idx++.
//    Last chunk (idx=NCHUNK-1): sum[WIDTH] <= carry-out, done <= 1, busy <= 0, state <= IDLE.
//  - Latency: done rises exactly NCHUNK edges after the accepting edge. busy is high for NCHUNK cycles.
//  - done is high for exactly one cycle. busy and done are never high together.
//  - start while busy=1: ignored; latched operands unchanged.
//  - start in the done cycle: accepted (busy=0); gives back-to-back ops with no idle gap.
//  - sum is meaningful only from the done cycle until the next accepted start.
//    It clears to 0 on accept; partial chunks are visible while busy.
//  - a, b and cin may change freely after acceptance.
//  - Arithmetic is unsigned modulo 2^(WIDTH+1). No saturation.
// CONFIGURATION
//  - Macro SEQ_ADDER_SUB_EN.
//  - Defined: adds input port `sub` (1 bit, sampled with a/b) and output port `ovf` (1 bit).
//    sub=1: B is latched as ~b, and the initial carry is forced to 1 (cin ignored), so sum[WIDTH-1:0]=a-b.
//    sum[WIDTH] = 1 means no borrow.
//    ovf: two's-complement signed overflow of the final chunk = carry into MSB XOR carry out of MSB.
//    ovf is registered with done and held like sum; it resets to 0.
//  - Undefined: no sub/ovf ports; addition only; behaviour identical to the sub=0 case.
// STRUCTURE
//  - Shared package seq_adder_pkg:
//    state encoding constants (IDLE, RUN);
//    function nchunk(WIDTH, CHUNK);
//    function clog2 for sizing idx (idx width = max(1, clog2(NCHUNK))).
//  - One sub-module, chunk_rca: combinational CHUNK-bit ripple-carry adder (a, b, ci -> s, co, c_msb).
//    c_msb is the carry into the MSB, used for ovf.
//    Single instance, reused every cycle.
//  - Parameter check at elaboration: WIDTH % CHUNK != 0 or CHUNK < 1 -> fatal.
// TESTING (WIDTH=8, CHUNK=4 unless stated)
//  1. Reset, then start with a=11, b=20, cin=0.
//     -> busy for 2 cycles; done pulses on the 2nd edge after accept; sum=9'd31.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=9'h100 (carry crosses the chunk boundary and exits).
//     a=8'hFF, b=8'hFF, cin=1 -> sum=9'h1FF.
//  3. start held high while busy, with a/b changed to 1/1.
//     -> first result unaffected (11+20=31); second op accepted in the done cycle; 1+1=2 two cycles later.
//  4. rst_n=0 for one edge during RUN.
//     -> next cycle busy=0, done=0, sum=0; no done pulse follows.
//  5. WIDTH=32, CHUNK=8: a=32'hFFFF_FFFF, b=1.
//     -> done 4 edges after accept; sum=33'h1_0000_0000.
//     Also WIDTH=8, CHUNK=8 -> done 1 edge after accept.
//  6. SEQ_ADDER_SUB_EN:
//     a=20, b=11, sub=1 -> sum=9'h109, ovf=0.
//     a=8'h80, b=1, sub=1 -> sum[7:0]=8'h7F, ovf=1.
//     a=5, b=9, sub=1 -> sum=9'h0FC.

Source files
------------

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// Used by seq_chunk_adder and its testbench.
package seq_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int nchunk(input int w, input int c);
    return (c < 1) ? 1 : w / c;
  endfunction

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_rca.sv
// Combinational CHUNK-bit ripple-carry slice, reused every cycle.
// c_msb is the carry into the top bit, for signed overflow.
module chunk_rca #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  assign {co, s} = {1'b0, a} + {1'b0, b}
                 + {{CHUNK{1'b0}}, ci};

  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock, carry held between chunks.
// Define SEQ_ADDER_SUB_EN to add the sub input and ovf output.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = idx_w(NCHUNK);
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_chk
    $fatal(1, "seq_chunk_adder: WIDTH must be a multiple of CHUNK >= 1");
  end

  state_t           r_state;
  state_t           w_next;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH:0]   r_sum;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  int               w_off;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_bin;
  logic             w_cin0;

`ifdef SEQ_ADDER_SUB_EN
  logic r_ovf;
  assign w_bin  = sub ? ~b : b;
  assign w_cin0 = sub | cin;
  assign ovf    = r_ovf;
`else
  logic w_unused_cmsb;
  assign w_bin         = b;
  assign w_cin0        = cin;
  assign w_unused_cmsb = w_cmsb;
`endif

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_idx == LAST);
  assign w_off    = int'(r_idx) * CHUNK;
  assign w_ca     = r_a[w_off +: CHUNK];
  assign w_cb     = r_b[w_off +: CHUNK];

  chunk_rca #(.CHUNK(CHUNK)) u_rca (
    .a     (w_ca),
    .b     (w_cb),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_cmsb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start)  w_next = RUN;
      RUN:  if (w_last) w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= w_bin;
        r_carry <= w_cin0;
        r_idx   <= '0;
        r_sum   <= '0;
      end else if (r_state == RUN) begin
        r_sum[w_off +: CHUNK] <= w_s;
        r_carry <= w_co;
        r_idx   <= r_idx + IDXW'(1);
        if (w_last) begin
          r_sum[WIDTH] <= w_co;
          r_done       <= 1'b1;
        end
      end
    end
  end

`ifdef SEQ_ADDER_SUB_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (w_accept)
      r_ovf <= 1'b0;
    else if ((r_state == RUN) && w_last)
      r_ovf <= w_cmsb ^ w_co;
  end
`endif

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign sum  = r_sum;

endmodule
